// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_t;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    localparam bcd2_t      BCD_ZERO = '{tens: 4'd0, ones: 4'd0};
    localparam logic [3:0] BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd2_step.sv
// Two-digit BCD add/subtract of a single-digit step, saturating at 00 and max_tens:9.
// Purely combinational.
module bcd2_step
    import timer_pkg::*;
(
    input  bcd2_t      value,
    input  logic [3:0] step,
    input  logic       dir,
    input  logic [3:0] max_tens,
    output bcd2_t      result,
    output logic       is_zero
);

    logic [4:0] sum;
    logic [4:0] borrowed;

    always_comb begin
        sum      = {1'b0, value.ones} + {1'b0, step};
        borrowed = {1'b0, value.ones} + 5'd10 - {1'b0, step};
        result   = value;
        if (!dir) begin
            if (sum > 5'd9) begin
                if (value.tens >= max_tens) begin
                    result.tens = max_tens;
                    result.ones = BCD_NINE;
                end else begin
                    result.tens = value.tens + 4'd1;
                    result.ones = 4'(sum - 5'd10);
                end
            end else begin
                result.ones = sum[3:0];
            end
        end else begin
            if (value.ones >= step) begin
                result.ones = value.ones - step;
            end else if (value.tens == 4'd0) begin
                result = BCD_ZERO;
            end else begin
                result.tens = value.tens - 4'd1;
                result.ones = borrowed[3:0];
            end
        end
        is_zero = (result == BCD_ZERO);
    end

endmodule

// File: rtl/countdown_sequencer.sv
// Setpoint entry and countdown FSM for a two-digit BCD timer; button effects visible 1 cycle after the edge.
// No backpressure. Define AUTOREPEAT_EN to repeat a held add/sub once per tick after a 2-tick hold.
module countdown_sequencer
    import timer_pkg::*;
#(
    parameter int STEP       = 1,
    parameter int MAX_TENS   = 9,
    parameter int DONE_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       add,
    input  logic       sub,
    input  logic       start,
    input  logic       stop,
    input  logic       tick,
    output logic [7:0] digits,
    output logic       running,
    output logic       done,
    output logic [2:0] state
);

    localparam int CW = (DONE_TICKS > 1) ? $clog2(DONE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DONE_TICKS - 1);

    state_t        cur, nxt;
    bcd2_t         val, val_nxt, step_out;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          add_q, sub_q, start_q, stop_q;
    logic          add_e, sub_e, start_e, stop_e;
    logic          rep, inc, dec, step_dir, step_zero, nonzero;
    logic [3:0]    step_amt;

    assign add_e   = add & ~add_q;
    assign sub_e   = sub & ~sub_q;
    assign start_e = start & ~start_q;
    assign stop_e  = stop & ~stop_q;
    assign nonzero = (val != BCD_ZERO);

`ifdef AUTOREPEAT_EN
    logic [1:0] hold_cnt;
    logic       hold_ok;

    assign hold_ok = (add ^ sub) & ~add_e & ~sub_e & ((cur == IDLE) || (cur == PAUSE));
    assign rep     = hold_ok & tick & (hold_cnt == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= 2'd0;
        end else if (!hold_ok) begin
            hold_cnt <= 2'd0;
        end else if (tick && hold_cnt != 2'd2) begin
            hold_cnt <= hold_cnt + 2'd1;
        end
    end
`else
    assign rep = 1'b0;
`endif

    assign inc = (add_e & ~sub_e) | (rep & add);
    assign dec = (sub_e & ~add_e) | (rep & sub);

    // One stepper serves both setpoint edits and the countdown decrement.
    assign step_amt = (cur == RUN) ? 4'd1 : 4'(STEP);
    assign step_dir = (cur == RUN) | dec;

    bcd2_step u_step (
        .value    (val),
        .step     (step_amt),
        .dir      (step_dir),
        .max_tens (4'(MAX_TENS)),
        .result   (step_out),
        .is_zero  (step_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= IDLE;
            val     <= BCD_ZERO;
            cnt     <= '0;
            add_q   <= 1'b0;
            sub_q   <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            cur     <= nxt;
            val     <= val_nxt;
            cnt     <= cnt_nxt;
            add_q   <= add;
            sub_q   <= sub;
            start_q <= start;
            stop_q  <= stop;
        end
    end

    always_comb begin
        nxt     = cur;
        val_nxt = val;
        cnt_nxt = cnt;
        case (cur)
            IDLE, PAUSE: begin
                if (stop_e) begin
                    val_nxt = BCD_ZERO;
                    nxt     = IDLE;
                end else if (start_e && nonzero) begin
                    nxt = RUN;
                end else if (inc || dec) begin
                    val_nxt = step_out;
                end
            end
            RUN: begin
                // Stop outranks a coincident tick so a pause never loses a count.
                if (stop_e) begin
                    nxt = PAUSE;
                end else if (tick) begin
                    val_nxt = step_out;
                    if (step_zero) begin
                        nxt     = DONE;
                        cnt_nxt = '0;
                    end
                end
            end
            DONE: begin
                val_nxt = BCD_ZERO;
                if (add_e || sub_e || start_e || stop_e) begin
                    nxt = IDLE;
                end else if (tick) begin
                    if (cnt == CNT_LAST) nxt = IDLE;
                    else                 cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                nxt     = IDLE;
                val_nxt = BCD_ZERO;
            end
        endcase
    end

    assign digits  = val;
    assign running = (cur == RUN);
    assign done    = (cur == DONE);
    assign state   = cur;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with a decimal-arithmetic reference model checked every cycle.
module tb_countdown_sequencer;

    localparam int STEP       = 1;
    localparam int MAX_TENS   = 9;
    localparam int DONE_TICKS = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       add = 1'b0, sub = 1'b0, start = 1'b0, stop = 1'b0, tick = 1'b0;
    logic [7:0] digits;
    logic       running, done;
    logic [2:0] state;

    int compared = 0;
    int mismatched = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    countdown_sequencer #(
        .STEP       (STEP),
        .MAX_TENS   (MAX_TENS),
        .DONE_TICKS (DONE_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .add     (add),
        .sub     (sub),
        .start   (start),
        .stop    (stop),
        .tick    (tick),
        .digits  (digits),
        .running (running),
        .done    (done),
        .state   (state)
    );

    // Reference model: value as a plain integer 0..99, state as 0..3.
    int m_val, m_st, m_cnt;
    bit p_add, p_sub, p_start, p_stop;

    function automatic void model_next(input int v, input int s, input int c,
                                       input bit ae, input bit be, input bit se,
                                       input bit pe, input bit t,
                                       output int nv, output int ns, output int nc);
        int ceil;
        ceil = MAX_TENS * 10 + 9;
        nv = v; ns = s; nc = c;
        case (s)
            0, 2: begin
                if (pe) begin
                    nv = 0; ns = 0;
                end else if (se && v != 0) begin
                    ns = 1;
                end else if (ae && !be) begin
                    nv = (v + STEP > ceil) ? ceil : v + STEP;
                end else if (be && !ae) begin
                    nv = (v < STEP) ? 0 : v - STEP;
                end
            end
            1: begin
                if (pe) begin
                    ns = 2;
                end else if (t) begin
                    nv = v - 1;
                    if (nv == 0) begin
                        ns = 3; nc = 0;
                    end
                end
            end
            default: begin
                nv = 0;
                if (ae || be || se || pe) ns = 0;
                else if (t) begin
                    if (c == DONE_TICKS - 1) ns = 0;
                    else nc = c + 1;
                end
            end
        endcase
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    always @(posedge clk or posedge reset) begin
        int nv, ns, nc;
        if (reset) begin
            m_val <= 0; m_st <= 0; m_cnt <= 0;
            p_add <= 1'b0; p_sub <= 1'b0; p_start <= 1'b0; p_stop <= 1'b0;
        end else begin
            model_next(m_val, m_st, m_cnt, add && !p_add, sub && !p_sub,
                       start && !p_start, stop && !p_stop, tick, nv, ns, nc);
            m_val <= nv; m_st <= ns; m_cnt <= nc;
            p_add <= add; p_sub <= sub; p_start <= start; p_stop <= stop;
        end
    end

    always @(negedge clk) begin
        logic [12:0] exp_v, act_v;
        if (armed && !reset) begin
            exp_v = {to_bcd(m_val), 3'(m_st), (m_st == 1), (m_st == 3)};
            act_v = {digits, state, running, done};
            compared++;
            if (act_v !== exp_v) begin
                mismatched++;
                $display("FAIL model_cmp t=%0t got {digits,state,run,done}=%h expected %h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("FAIL %s got %h expected %h", nm, act, exp_v);
        end
    endtask

    task automatic cyc(input bit a, input bit b, input bit s, input bit p, input bit t);
        add = a; sub = b; start = s; stop = p; tick = t;
        @(negedge clk);
    endtask

    // code: 0 add, 1 sub, 2 start, 3 stop, 4 tick
    task automatic press(input int code, input int n);
        for (int i = 0; i < n; i++) begin
            cyc(code == 0, code == 1, code == 2, code == 3, code == 4);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_digits", digits, 8'h00);
        chk("reset_state", 8'(state), 8'h00);
        chk("reset_running", 8'(running), 8'h00);
        chk("reset_done", 8'(done), 8'h00);
        reset = 1'b0;
        armed = 1'b1;
        @(negedge clk);

        press(0, 3);
        chk("three_adds", digits, 8'h03);
        press(2, 1);
        chk("start_running", 8'(running), 8'h01);
        press(4, 1);
        chk("tick1", digits, 8'h02);
        press(4, 1);
        chk("tick2", digits, 8'h01);
        press(4, 1);
        chk("tick3_digits", digits, 8'h00);
        chk("tick3_done", 8'(done), 8'h01);
        press(4, 2);
        chk("done_after_2_ticks", 8'(done), 8'h01);
        press(4, 1);
        chk("done_cleared", 8'(done), 8'h00);
        chk("done_to_idle", 8'(state), 8'h00);

        press(0, 9);
        chk("set_09", digits, 8'h09);
        press(0, 1);
        chk("carry_10", digits, 8'h10);
        press(0, 95);
        chk("saturate_99", digits, 8'h99);
        press(3, 1);
        chk("clear_00", digits, 8'h00);
        press(1, 1);
        chk("sub_floor_00", digits, 8'h00);

        press(0, 10);
        press(2, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 0, 0, 0, 0);
        chk("stop_wins_state", 8'(state), 8'h02);
        chk("stop_wins_digits", digits, 8'h10);
        press(2, 1);
        chk("resume_run", 8'(state), 8'h01);
        press(4, 1);
        chk("borrow_09", digits, 8'h09);

        press(4, 4);
        chk("run_05", digits, 8'h05);
        press(3, 1);
        chk("pause_05", 8'(state), 8'h02);
        press(3, 1);
        chk("pause_clear_state", 8'(state), 8'h00);
        chk("pause_clear_digits", digits, 8'h00);
        press(2, 1);
        chk("start_at_zero_state", 8'(state), 8'h00);
        chk("start_at_zero_run", 8'(running), 8'h00);

        press(0, 1);
        press(2, 1);
        press(4, 1);
        chk("reach_done", 8'(state), 8'h03);
        cyc(1, 0, 0, 0, 0);
        chk("add_in_done_state", 8'(state), 8'h00);
        chk("add_in_done_digits", digits, 8'h00);
        cyc(0, 0, 0, 0, 0);

        press(0, 42);
        press(2, 1);
        chk("run_42", digits, 8'h42);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_digits", digits, 8'h00);
        chk("async_rst_running", 8'(running), 8'h00);
        chk("async_rst_state", 8'(state), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
